// File: rtl/aes_pkg.sv
// Shared AES MixColumns types and GF(2^8) arithmetic helpers.
// Bytes are addressed as state[row][col], matching the AES state layout.
package aes_pkg;

  typedef logic [0:3][0:3][7:0] state_t;
  typedef logic [0:3][7:0]      column_t;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b this folds to a few xtime/XOR terms.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 4-byte column.
// Each matrix row is the base row rotated right by the row index.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [0:3][7:0] col,
  input  logic            inverse,
  output logic [0:3][7:0] mixed
);

  localparam logic [0:3][7:0] FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] INV_ROW = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  always_comb begin
    logic [1:0] idx;
    logic [7:0] coef;
    idx   = 2'd0;
    coef  = 8'h00;
    mixed = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        idx      = 2'(k + 4 - r);
        coef     = inverse ? INV_ROW[idx] : FWD_ROW[idx];
        mixed[r] = mixed[r] ^ gf_mul(col[k], coef);
      end
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: captures a state, mixes COLS_PER_CYCLE columns
// per cycle in place, then holds the result until the consumer takes it.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inverse,
  input  logic [0:3][0:3][7:0]  state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:3][0:3][7:0]  state_out,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // With 4 columns per cycle the step wraps to 0, so cnt simply stays at 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and flush overrides both directions.

  fsm_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  state_t     work_q, work_d;

  column_t col_in  [COLS_PER_CYCLE];
  column_t col_out [COLS_PER_CYCLE];

  always_comb begin
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx = cnt_q + 2'(k);
      for (int r = 0; r < 4; r++) begin
        col_in[k][r] = work_q[r][idx];
      end
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    mix_single_column u_mix (
      .col     (col_in[g]),
      .inverse (mode_q),
      .mixed   (col_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    work_d    = work_q;
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    state_out = work_q;
    dbg_state = state_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = RUN;
            cnt_d   = 2'd0;
            mode_d  = (INV_EN != 0) && in_inverse;
            work_d  = state_in;
          end
        end
        RUN: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx = cnt_q + 2'(k);
            for (int r = 0; r < 4; r++) begin
              work_d[r][idx] = col_out[k][r];
            end
          end
          cnt_d = cnt_q + CNT_STEP;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: known AES vectors plus random states against a
// polynomial-arithmetic reference, on three parameterisations.
module tb_mix_columns_engine;

  typedef logic [0:3][0:3][7:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_inverse, out_ready;
  logic iv1, iv2, iv4;
  st_t  state_in;
  logic ir1, ir2, ir4, ov1, ov2, ov4, bz1, bz2, bz4;
  st_t  so1, so2, so4;
  logic [1:0] ds1, ds2, ds4;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [127:0] exp_q[$];

  mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_inverse(in_inverse), .state_in(state_in), .out_valid(ov1), .out_ready(out_ready),
    .state_out(so1), .busy(bz1), .dbg_state(ds1));
  mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_EN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv2), .in_ready(ir2),
    .in_inverse(in_inverse), .state_in(state_in), .out_valid(ov2), .out_ready(out_ready),
    .state_out(so2), .busy(bz2), .dbg_state(ds2));
  mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_EN(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv4), .in_ready(ir4),
    .in_inverse(in_inverse), .state_in(state_in), .out_valid(ov4), .out_ready(out_ready),
    .state_out(so4), .busy(bz4), .dbg_state(ds4));

  // Reference: carry-less product, then reduce by x^8+x^4+x^3+x+1 from the top bit down.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic st_t ref_mix(input st_t s, input logic inv);
    logic [7:0] base [4];
    st_t o;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[r][c] = o[r][c] ^ ref_mul(base[(k - r + 4) % 4], s[k][c]);
    return o;
  endfunction

  function automatic st_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                    input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cs [4];
    st_t s;
    cs = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = cs[c][31 - 8 * r -: 8];
    return s;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = 8'($urandom_range(0, 255));
    return s;
  endfunction

  function automatic logic get_ready(input int w);
    case (w) 2: return ir2; 4: return ir4; default: return ir1; endcase
  endfunction

  function automatic logic get_valid(input int w);
    case (w) 2: return ov2; 4: return ov4; default: return ov1; endcase
  endfunction

  function automatic st_t get_out(input int w);
    case (w) 2: return so2; 4: return so4; default: return so1; endcase
  endfunction

  task automatic set_valid(input int w, input logic v);
    case (w) 2: iv2 = v; 4: iv4 = v; default: iv1 = v; endcase
  endtask

  // Driver: offer one state, count edges from accept to out_valid, then take the result.
  task automatic transact(input int w, input st_t s, input logic inv, output st_t res, output int lat);
    int n;
    n = 0;
    while (!get_ready(w) && n < 20) begin @(negedge clk); n++; end
    state_in = s;
    in_inverse = inv;
    set_valid(w, 1'b1);
    @(posedge clk); #1;
    set_valid(w, 1'b0);
    lat = 0;
    while (lat < 20 && !get_valid(w)) begin @(posedge clk); #1; lat++; end
    res = get_out(w);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    st_t s, res;
    int n;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_inverse = 1'b0;
    iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0; state_in = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (ir1 !== 1'b1) begin fail_cnt++; $display("FAIL reset_in_ready: got %b want 1", ir1); end
    tests_run++; if (ov1 !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %b want 0", ov1); end
    tests_run++; if (bz1 !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b want 0", bz1); end
    tests_run++; if (so1 !== '0) begin fail_cnt++; $display("FAIL reset_state_out: got %h want 0", so1); end
    tests_run++; if ({ov2, ov4, bz2, bz4} !== 4'b0) begin fail_cnt++; $display("FAIL reset_aux: got %b want 0000", {ov2, ov4, bz2, bz4}); end
    @(negedge clk);
    rst_n = 1'b1;
    s = rand_state();
    state_in = s; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    tests_run++; if (bz1 !== 1'b1) begin fail_cnt++; $display("FAIL first_accept_busy: got %b want 1", bz1); end
    n = 0;
    while (n < 20 && !ov1) begin @(posedge clk); #1; n++; end
    res = so1;
    tests_run++; if (res !== ref_mix(s, 1'b0)) begin fail_cnt++; $display("FAIL first_accept_result: got %h want %h", res, ref_mix(s, 1'b0)); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_forward();
    st_t k, e, res, s;
    int lat;
    k = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    e = from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    transact(1, k, 1'b0, res, lat);
    tests_run++; if (res !== e) begin fail_cnt++; $display("FAIL fwd_known: got %h want %h", res, e); end
    tests_run++; if (lat !== 4) begin fail_cnt++; $display("FAIL fwd_latency: got %0d want 4", lat); end
    for (int i = 0; i < 6; i++) begin
      s = rand_state();
      transact(1, s, 1'b0, res, lat);
      tests_run++; if (res !== ref_mix(s, 1'b0) || lat !== 4) begin
        fail_cnt++; $display("FAIL fwd_random: got %h lat %0d want %h lat 4", res, lat, ref_mix(s, 1'b0)); end
    end
  endtask

  task automatic test_inverse();
    st_t k, e, d, de, res, s;
    int lat;
    k  = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    e  = from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    d  = from_cols(32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5);
    de = from_cols(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6);
    transact(1, e, 1'b1, res, lat);
    tests_run++; if (res !== k) begin fail_cnt++; $display("FAIL inv_roundtrip: got %h want %h", res, k); end
    transact(1, d, 1'b0, res, lat);
    tests_run++; if (res !== de) begin fail_cnt++; $display("FAIL fwd_d4: got %h want %h", res, de); end
    transact(1, res, 1'b1, res, lat);
    tests_run++; if (res !== d) begin fail_cnt++; $display("FAIL inv_d4: got %h want %h", res, d); end
    for (int i = 0; i < 6; i++) begin
      s = rand_state();
      transact(1, s, 1'b1, res, lat);
      tests_run++; if (res !== ref_mix(s, 1'b1) || lat !== 4) begin
        fail_cnt++; $display("FAIL inv_random: got %h lat %0d want %h lat 4", res, lat, ref_mix(s, 1'b1)); end
    end
  endtask

  task automatic test_params();
    st_t k, e, res, s;
    int lat;
    k = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    e = from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    transact(2, k, 1'b0, res, lat);
    tests_run++; if (res !== e || lat !== 2) begin fail_cnt++; $display("FAIL cols2_known: got %h lat %0d want %h lat 2", res, lat, e); end
    transact(4, k, 1'b1, res, lat);
    tests_run++; if (res !== e || lat !== 1) begin fail_cnt++; $display("FAIL cols4_noinv_known: got %h lat %0d want %h lat 1", res, lat, e); end
    for (int i = 0; i < 4; i++) begin
      s = rand_state();
      transact(2, s, 1'b1, res, lat);
      tests_run++; if (res !== ref_mix(s, 1'b1)) begin fail_cnt++; $display("FAIL cols2_inv_random: got %h want %h", res, ref_mix(s, 1'b1)); end
      transact(4, s, 1'($urandom_range(0, 1)), res, lat);
      tests_run++; if (res !== ref_mix(s, 1'b0)) begin fail_cnt++; $display("FAIL cols4_random: got %h want %h", res, ref_mix(s, 1'b0)); end
    end
  endtask

  task automatic test_backpressure();
    st_t s, e;
    int n;
    s = rand_state();
    e = ref_mix(s, 1'b0);
    in_inverse = 1'b0; state_in = s; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (n < 20 && !ov1) begin @(posedge clk); #1; n++; end
    iv1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      state_in = rand_state();
      @(posedge clk); #1;
      tests_run++; if (so1 !== e || ir1 !== 1'b0 || ov1 !== 1'b1) begin
        fail_cnt++; $display("FAIL backpressure_hold: got %h ir %b ov %b want %h ir 0 ov 1", so1, ir1, ov1, e); end
    end
    iv1 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++; if (bz1 !== 1'b0 || ir1 !== 1'b1 || ov1 !== 1'b0) begin
      fail_cnt++; $display("FAIL backpressure_release: got busy %b ir %b ov %b want 0 1 0", bz1, ir1, ov1); end
  endtask

  task automatic test_flush();
    st_t s, res;
    int lat, seen, n;
    state_in = rand_state(); in_inverse = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; iv1 = 1'b1; state_in = rand_state();
    #1;
    tests_run++; if (ir1 !== 1'b0) begin fail_cnt++; $display("FAIL flush_in_ready: got %b want 0", ir1); end
    @(posedge clk); #1;
    flush = 1'b0; iv1 = 1'b0;
    tests_run++; if (bz1 !== 1'b0 || ov1 !== 1'b0) begin fail_cnt++; $display("FAIL flush_idle: got busy %b ov %b want 0 0", bz1, ov1); end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ov1) seen++; end
    tests_run++; if (seen !== 0) begin fail_cnt++; $display("FAIL flush_no_output: got %0d want 0", seen); end
    s = rand_state();
    transact(1, s, 1'b1, res, lat);
    tests_run++; if (res !== ref_mix(s, 1'b1) || lat !== 4) begin fail_cnt++; $display("FAIL flush_next: got %h lat %0d want %h lat 4", res, lat, ref_mix(s, 1'b1)); end
    state_in = rand_state(); iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (n < 20 && !ov1) begin @(posedge clk); #1; n++; end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    tests_run++; if (ov1 !== 1'b0 || bz1 !== 1'b0) begin fail_cnt++; $display("FAIL flush_done: got ov %b busy %b want 0 0", ov1, bz1); end
    s = rand_state();
    transact(1, s, 1'b0, res, lat);
    tests_run++; if (res !== ref_mix(s, 1'b0)) begin fail_cnt++; $display("FAIL flush_done_next: got %h want %h", res, ref_mix(s, 1'b0)); end
  endtask

  task automatic test_reset_mid_run();
    st_t s, res;
    int lat, seen;
    state_in = rand_state(); in_inverse = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #3;
    tests_run++; if (bz1 !== 1'b1) begin fail_cnt++; $display("FAIL midrun_busy: got %b want 1", bz1); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (ov1 !== 1'b0 || bz1 !== 1'b0 || so1 !== '0 || ir1 !== 1'b1) begin
      fail_cnt++; $display("FAIL midrun_reset: got ov %b busy %b ir %b out %h want 0 0 1 0", ov1, bz1, ir1, so1); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ov1 || bz1) seen++; end
    tests_run++; if (seen !== 0) begin fail_cnt++; $display("FAIL midrun_spurious: got %0d want 0", seen); end
    s = rand_state();
    transact(1, s, 1'b0, res, lat);
    tests_run++; if (res !== ref_mix(s, 1'b0)) begin fail_cnt++; $display("FAIL midrun_next: got %h want %h", res, ref_mix(s, 1'b0)); end
  endtask

  task automatic test_back_to_back();
    int outs;
    logic [127:0] exp_v;
    outs = 0;
    exp_q.delete();
    state_in = rand_state(); in_inverse = 1'($urandom_range(0, 1));
    iv1 = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (iv1 && ir1) exp_q.push_back(ref_mix(state_in, in_inverse));
      if (ov1 && out_ready) begin
        outs++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        tests_run++; if (so1 !== exp_v) begin fail_cnt++; $display("FAIL b2b_data: got %h want %h", so1, exp_v); end
      end
      @(posedge clk); #1;
      state_in = rand_state(); in_inverse = 1'($urandom_range(0, 1));
    end
    iv1 = 1'b0; out_ready = 1'b0;
    tests_run++; if (outs !== 4 || exp_q.size() !== 0) begin
      fail_cnt++; $display("FAIL b2b_throughput: got %0d outputs %0d pending want 4 0", outs, exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_params();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per cycle, legal values 1, 2 and 4; any other value is an elaboration error.
REQ-002 SHALL have parameter INV_EN, default 1; 1 builds InvMixColumns support, 0 builds forward only.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1, synchronous abort.
REQ-006 SHALL have port in_valid, input, 1, input state offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept a state.
REQ-008 SHALL have port in_inverse, input, 1, inverse mode, sampled with the input handshake.
REQ-009 SHALL have port state_in, input, 8 x [0:3][0:3] indexed [row][col], state to transform.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port state_out, output, 8 x [0:3][0:3] indexed [row][col], transformed state.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-014 SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-015 in_ready SHALL equal (state==IDLE) && !flush.
REQ-016 An accept (in_valid && in_ready) in IDLE SHALL do all of the following at the same edge: capture state_in into a working register, capture in_inverse (forced to 0 when INV_EN=0), clear the column counter, and enter RUN.
REQ-017 In each RUN cycle, the block SHALL replace columns cnt..cnt+COLS_PER_CYCLE-1 of the working register in place and advance cnt by COLS_PER_CYCLE.
REQ-018 RUN SHALL last exactly 4/COLS_PER_CYCLE cycles; the edge that processes the last column SHALL move the FSM to DONE.
REQ-019 Forward mode SHALL apply the matrix rows (02 03 01 01), (01 02 03 01), (01 01 02 03) and (03 01 01 02).
REQ-020 Inverse mode SHALL apply the matrix rows (0e 0b 0d 09), (09 0e 0b 0d), (0d 09 0e 0b) and (0b 0d 09 0e).
REQ-021 All products SHALL be GF(2^8) multiplications modulo x^8+x^4+x^3+x+1, reducing by 8'h1b on each xtime, and additions SHALL be XOR.
REQ-022 out_valid SHALL be 1 exactly in DONE, so it rises 4/COLS_PER_CYCLE cycles after the accept edge.
REQ-023 state_out SHALL always equal the working register, and SHALL stay stable while out_valid && !out_ready.
REQ-024 out_valid && out_ready in DONE SHALL return the FSM to IDLE; the next accept is possible on the following cycle, giving a throughput of one state per 4/COLS_PER_CYCLE+2 cycles.
REQ-025 in_valid SHALL be ignored outside IDLE; no input is queued.
REQ-026 flush=1 in any state SHALL do all of the following at the next edge: enter IDLE, clear cnt, and drop out_valid; the working data is discarded.
REQ-027 flush together with in_valid in IDLE SHALL not accept the input, because in_ready is 0.
REQ-028 flush together with out_ready in DONE SHALL count as a flush, and the consumer SHALL not treat it as a completed transfer.
REQ-029 The column counter SHALL be 2 bits wide and wrap only via the DONE transition; it SHALL never index past column 3.

Reset
REQ-030 rst_n low SHALL asynchronously force all of the following: FSM to IDLE, cnt=0, mode=0, working register to all zero.
REQ-031 Under reset, the outputs SHALL be in_ready=1 (when flush=0), out_valid=0, busy=0, and state_out all zero.
REQ-032 Reset mid-RUN SHALL discard the operation, and no out_valid SHALL follow.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package aes_pkg SHALL hold the following: the state_t typedef (8-bit [0:3][0:3]), the column typedef, the constant GF_POLY = 8'h1b, and the xtime and gf_mul functions.
REQ-035 Sub-module mix_single_column SHALL be combinational and take a 4-byte column plus an inverse flag, returning the mixed column.
REQ-036 The block SHALL instantiate mix_single_column COLS_PER_CYCLE times, fed through a cnt-indexed column mux.

Verification
REQ-037 Forward test, COLS_PER_CYCLE=1: state_in columns db135345, f20a225c, 01010101, c6c6c6c6 with in_inverse=0 -> state_out columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6, and out_valid rising exactly 4 cycles after the accept.
REQ-038 Inverse round-trip: feed the REQ-037 output with in_inverse=1 -> original columns restored; column d4d4d4d5 forward -> d5d5d7d6, and inverse restores it.
REQ-039 Latency per parameter value: COLS_PER_CYCLE=2 gives latency 2 and COLS_PER_CYCLE=4 gives latency 1, with results identical to REQ-037; INV_EN=0 with in_inverse=1 gives the forward result.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE -> state_out stable, in_ready=0 and in_valid ignored; release -> IDLE on the next cycle.
REQ-041 Flush at RUN cycle 2, including a same-cycle in_valid -> IDLE with no out_valid, that input not accepted, and the next input processing correctly.
REQ-042 Reset test: assert rst_n low asynchronously mid-RUN -> out_valid=0, state_out all zero, busy=0 immediately, and no spurious result after release.
